// File: rtl/mos6502_bus_ctrl_if.sv
// Core-side and pad-side signal bundle of the 6502 external-bus controller.
// slave = the controller itself; master = whatever drives the core/pad side (core + pads, or a bench).
interface mos6502_bus_ctrl_if;
    logic        enable;
    logic [2:0]  wait_cfg;
    logic [15:0] core_addr;
    logic [7:0]  core_dout;
    logic        core_we;
    logic [7:0]  core_din;
    logic        core_rdy;
    logic [15:0] io_addr;
    logic [7:0]  io_dout;
    logic [7:0]  io_oeb;
    logic [7:0]  io_din;
    logic        io_we;
    logic        io_wait_n;
    logic        bus_err;
    logic        busy;

    modport slave (
        input  enable, wait_cfg, core_addr, core_dout, core_we, io_din, io_wait_n,
        output core_din, core_rdy, io_addr, io_dout, io_oeb, io_we, bus_err, busy
    );

    modport master (
        output enable, wait_cfg, core_addr, core_dout, core_we, io_din, io_wait_n,
        input  core_din, core_rdy, io_addr, io_dout, io_oeb, io_we, bus_err, busy
    );
endinterface

// File: rtl/mos6502_bus_ctrl.sv
// Registers 6502 accesses onto the pads; latency 3 + wait_cfg + slave stretch clocks.
// Backpressure: core is held with core_rdy low until the one-cycle COMPLETE pulse.
module mos6502_bus_ctrl #(
    parameter int          TIMEOUT     = 255,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_DATA   = 8'hFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    mos6502_bus_ctrl_if.slave bus
);
    localparam int             TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMPLETE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_wcnt, w_wcnt_nxt;
    logic [TW-1:0]          r_tcnt, w_tcnt_nxt, w_tcnt_inc;
    logic [15:0]            r_io_addr, w_io_addr_nxt;
    logic [7:0]             r_io_dout, w_io_dout_nxt;
    logic                   r_io_we, w_io_we_nxt;
    logic [7:0]             r_core_din, w_core_din_nxt;
    logic                   r_bus_err, w_bus_err_nxt;
    logic                   w_wait_s;

    assign w_wait_s   = r_sync[SYNC_STAGES-1];
    assign w_tcnt_inc = r_tcnt + 1'b1;

    // Synchroniser idles high so a missing slave never looks like a wait request.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_sync <= '1;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], bus.io_wait_n};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_tcnt     <= '0;
            r_io_addr  <= '0;
            r_io_dout  <= '0;
            r_io_we    <= 1'b0;
            r_core_din <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_io_addr  <= w_io_addr_nxt;
            r_io_dout  <= w_io_dout_nxt;
            r_io_we    <= w_io_we_nxt;
            r_core_din <= w_core_din_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_tcnt_nxt     = r_tcnt;
        w_io_addr_nxt  = r_io_addr;
        w_io_dout_nxt  = r_io_dout;
        w_io_we_nxt    = r_io_we;
        w_core_din_nxt = r_core_din;
        w_bus_err_nxt  = r_bus_err;
        case (r_state)
            S_IDLE: begin
                if (bus.enable) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_io_addr_nxt = bus.core_addr;
                    w_io_dout_nxt = bus.core_dout;
                    w_io_we_nxt   = bus.core_we;
                    w_wcnt_nxt    = bus.wait_cfg;
                    w_tcnt_nxt    = '0;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wcnt != 3'd0) begin
                    w_wcnt_nxt = r_wcnt - 3'd1;
                end else if (w_wait_s) begin
                    w_state_nxt = S_COMPLETE;
                    w_io_we_nxt = 1'b0;
                    if (!r_io_we) w_core_din_nxt = bus.io_din;
                end else begin
                    // Slave has held WAIT for TIMEOUT cycles: abandon the access.
                    w_tcnt_nxt = w_tcnt_inc;
                    if (w_tcnt_inc == TMO) begin
                        w_state_nxt   = S_COMPLETE;
                        w_io_we_nxt   = 1'b0;
                        w_bus_err_nxt = 1'b1;
                        if (!r_io_we) w_core_din_nxt = IDLE_DATA;
                    end
                end
            end
            S_COMPLETE: begin
                w_state_nxt = S_LAUNCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.core_rdy = (r_state == S_COMPLETE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.io_oeb   = (r_state == S_WAIT && r_io_we) ? 8'h00 : 8'hFF;
    assign bus.io_addr  = r_io_addr;
    assign bus.io_dout  = r_io_dout;
    assign bus.io_we    = r_io_we;
    assign bus.core_din = r_core_din;
    assign bus.bus_err  = r_bus_err;
endmodule

// File: tb/tb_mos6502_bus_ctrl.sv
// Directed and random 6502 bus accesses checked against a cycle-count reference
// derived from wait states, synchroniser delay and timeout rules.
module tb_mos6502_bus_ctrl;
    localparam int TMO = 8;
    localparam int SS  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mos6502_bus_ctrl_if bus ();

    mos6502_bus_ctrl #(.TIMEOUT(TMO), .SYNC_STAGES(SS), .IDLE_DATA(8'hFF)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_din;
    logic       exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Slave wait pattern: low during access cycles [lo_s, lo_e); cycle 0 is the first WAIT cycle.
    function automatic logic wn(input int k, input int lo_s, input int lo_e);
        return !(k >= lo_s && k < lo_e);
    endfunction

    // Called at the negedge of a LAUNCH cycle; returns at the negedge of the following cycle.
    task automatic access(input logic [15:0] a, input logic [7:0] d, input logic we,
                          input int wcfg, input int lo_s, input int lo_e,
                          input logic [7:0] din, input bit drop_en);
        int kx;
        int lows;
        bit tmo;
        kx = 0; lows = 0; tmo = 0;
        // Reference: wait states first, then the slave's WAIT seen SS cycles late, capped at TMO lows.
        for (int k = wcfg; k < wcfg + TMO + 1; k++) begin
            if (wn(k - SS, lo_s, lo_e)) begin
                kx = k;
                break;
            end
            lows++;
            if (lows == TMO) begin
                kx  = k;
                tmo = 1;
                break;
            end
        end

        bus.core_addr = a;
        bus.core_dout = d;
        bus.core_we   = we;
        bus.wait_cfg  = 3'(wcfg);
        bus.io_din    = ~din;
        bus.io_wait_n = wn(-1, lo_s, lo_e);
        chk("launch_rdy",  32'(bus.core_rdy), 32'd0);
        chk("launch_busy", 32'(bus.busy),     32'd1);
        chk("launch_oeb",  32'(bus.io_oeb),   32'hFF);
        chk("launch_we",   32'(bus.io_we),    32'd0);

        for (int k = 0; k <= kx; k++) begin
            @(negedge clk);
            chk("wait_addr", 32'(bus.io_addr),  32'(a));
            chk("wait_dout", 32'(bus.io_dout),  32'(d));
            chk("wait_we",   32'(bus.io_we),    32'(we));
            chk("wait_oeb",  32'(bus.io_oeb),   we ? 32'h00 : 32'hFF);
            chk("wait_rdy",  32'(bus.core_rdy), 32'd0);
            chk("wait_busy", 32'(bus.busy),     32'd1);
            if (k == 0) begin
                bus.core_addr = ~a;
                bus.core_dout = ~d;
                bus.core_we   = ~we;
                bus.wait_cfg  = 3'(7 - wcfg);
                if (drop_en) bus.enable = 1'b0;
            end
            if (k == kx) bus.io_din = din;
            bus.io_wait_n = wn(k, lo_s, lo_e);
        end

        @(negedge clk);
        if (!we) exp_din = tmo ? 8'hFF : din;
        if (tmo) exp_err = 1'b1;
        chk("cmpl_rdy",  32'(bus.core_rdy), 32'd1);
        chk("cmpl_we",   32'(bus.io_we),    32'd0);
        chk("cmpl_oeb",  32'(bus.io_oeb),   32'hFF);
        chk("cmpl_addr", 32'(bus.io_addr),  32'(a));
        chk("cmpl_din",  32'(bus.core_din), 32'(exp_din));
        chk("cmpl_err",  32'(bus.bus_err),  32'(exp_err));
        bus.io_wait_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.wait_cfg  = 3'd0;
        bus.core_addr = 16'h0;
        bus.core_dout = 8'h0;
        bus.core_we   = 1'b0;
        bus.io_din    = 8'h0;
        bus.io_wait_n = 1'b1;
        exp_din       = 8'h00;
        exp_err       = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(bus.io_addr),  32'h0);
        chk("rst_dout", 32'(bus.io_dout),  32'h0);
        chk("rst_we",   32'(bus.io_we),    32'h0);
        chk("rst_oeb",  32'(bus.io_oeb),   32'hFF);
        chk("rst_din",  32'(bus.core_din), 32'h0);
        chk("rst_rdy",  32'(bus.core_rdy), 32'h0);
        chk("rst_err",  32'(bus.bus_err),  32'h0);
        chk("rst_busy", 32'(bus.busy),     32'h0);

        rst = 1'b0;
        @(negedge clk);
        chk("idle_disabled", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;
        @(negedge clk);

        access(16'hFFFC, 8'h00, 1'b0, 0, 0, 0,   8'h34, 1'b0);
        access(16'h3055, 8'h1C, 1'b1, 2, 0, 0,   8'h00, 1'b0);
        access(16'h1234, 8'h00, 1'b0, 2, 0, 4,   8'h5A, 1'b0);
        access(16'h2000, 8'h00, 1'b0, 3, 0, 100, 8'hA5, 1'b0);
        access(16'h2001, 8'h66, 1'b1, 0, 0, 0,   8'h00, 1'b0);
        access(16'h2002, 8'h00, 1'b0, 1, 0, 0,   8'hC3, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int          wc;
            int          ls;
            int          le;
            logic [15:0] ra;
            logic [7:0]  rd;
            logic [7:0]  ri;
            logic        rw;
            wc = int'($urandom_range(0, 7));
            ls = 0;
            le = 0;
            if (wc >= SS) begin
                ls = int'($urandom_range(0, 3));
                le = ls + int'($urandom_range(0, 12));
            end
            ra = 16'($urandom);
            rd = 8'($urandom);
            ri = 8'($urandom);
            rw = 1'($urandom_range(0, 1));
            access(ra, rd, rw, wc, ls, le, ri, 1'b0);
        end

        access(16'h4000, 8'h00, 1'b0, 2, 0, 0, 8'h99, 1'b1);
        @(negedge clk);
        chk("drop_busy", 32'(bus.busy),     32'd0);
        chk("drop_oeb",  32'(bus.io_oeb),   32'hFF);
        chk("drop_rdy",  32'(bus.core_rdy), 32'd0);
        repeat (2) @(negedge clk);
        chk("drop_idle_busy", 32'(bus.busy),     32'd0);
        chk("drop_idle_rdy",  32'(bus.core_rdy), 32'd0);

        bus.enable = 1'b1;
        @(negedge clk);
        bus.core_addr = 16'h4321;
        bus.core_dout = 8'h77;
        bus.core_we   = 1'b1;
        bus.wait_cfg  = 3'd5;
        @(negedge clk);
        chk("prerst_we",  32'(bus.io_we),  32'd1);
        chk("prerst_oeb", 32'(bus.io_oeb), 32'h00);
        rst = 1'b1;
        #1;
        exp_din = 8'h00;
        exp_err = 1'b0;
        chk("midrst_we",   32'(bus.io_we),    32'd0);
        chk("midrst_oeb",  32'(bus.io_oeb),   32'hFF);
        chk("midrst_rdy",  32'(bus.core_rdy), 32'd0);
        chk("midrst_busy", 32'(bus.busy),     32'd0);
        chk("midrst_addr", 32'(bus.io_addr),  32'h0);
        chk("midrst_err",  32'(bus.bus_err),  32'd0);
        @(negedge clk);
        chk("midrst_rdy2", 32'(bus.core_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        access(16'h8000, 8'h00, 1'b0, 0, 0, 0, 8'h3C, 1'b0);
        access(16'h8001, 8'hE1, 1'b1, 4, 1, 3, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
